// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential unsigned divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    localparam int DIV_DEFAULT_WIDTH = 18;

endpackage

// File: rtl/seq_divider_unsigned_div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// subtract the divisor when it fits.
import seq_divider_pkg::*;

module div_step #(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    // The remainder is always below the divisor, so its top bit is zero here.
    logic           rem_top_unused;

    assign rem_top_unused = rem[WIDTH];
    assign shifted        = {rem[WIDTH-1:0], quo_msb};
    assign q_bit          = (shifted >= {1'b0, divisor});
    assign next_rem       = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/seq_divider_unsigned.sv
// Multi-cycle unsigned divider, one quotient bit per clock, with
// valid/ready handshakes on operands and results.
import seq_divider_pkg::*;

module seq_divider_unsigned #(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state, state_d;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   next_rem;
    logic             q_bit;
    logic [CNT_W-1:0] cnt;
    logic             dbz;
    logic             accept;

    assign in_ready    = (state == IDLE) && !rst;
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state == DONE);
    assign q           = quo;
    assign r           = rem[WIDTH-1:0];
    assign div_by_zero = dbz;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo_msb  (quo[WIDTH-1]),
        .divisor  (divisor),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = (b == '0) ? DONE : BUSY;
            BUSY: if (cnt == CNT_W'(1)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            dbz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        divisor <= b;
                        cnt     <= CNT_W'(WIDTH);
                        if (b == '0) begin
                            // Divide by zero skips iteration: saturated quotient, dividend as remainder.
                            quo <= '1;
                            rem <= {1'b0, a};
                            dbz <= 1'b1;
                        end else begin
                            quo <= a;
                            rem <= '0;
                            dbz <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    rem <= next_rem;
                    quo <= {quo[WIDTH-2:0], q_bit};
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_unsigned.sv
// Directed-vector and random bench for seq_divider_unsigned.
module tb_seq_divider_unsigned;

    localparam int W = 18;
    localparam logic [W-1:0] MAXV = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           stall;
        bit           pulse;
    } vec_t;

    seq_divider_unsigned #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Issue one operation, wait for the result, optionally stall the consumer.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                         input int stall, input bit pulse);
        int w;
        int lat;
        @(negedge clk);
        a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check({tag, " accept timeout"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb_;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check({tag, " latency"}, 64'(lat), (tb_ == '0) ? 64'd1 : 64'(W + 1));
        check({tag, " q"}, 64'(q), 64'(eq));
        check({tag, " r"}, 64'(r), 64'(er));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(ed));
        for (int s = 0; s < stall; s++) begin
            if (pulse && s == 1) begin
                in_valid = 1'b1; a = 18'd3; b = 18'd1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check({tag, " stall valid"}, 64'(out_valid), 64'd1);
            check({tag, " stall q"}, 64'(q), 64'(eq));
            check({tag, " stall r"}, 64'(r), 64'(er));
            check({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " done valid"}, 64'(out_valid), 64'd0);
        check({tag, " done in_ready"}, 64'(in_ready), 64'd1);
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] ra, rb, rq, rr;
        logic         rd;
        bit           seen;
        int           lat;

        vecs[0] = '{18'd100,    18'd7,      18'd14,     18'd2,    1'b0, 0, 1'b0};
        vecs[1] = '{18'd262143, 18'd1,      18'd262143, 18'd0,    1'b0, 0, 1'b0};
        vecs[2] = '{18'd5,      18'd9,      18'd0,      18'd5,    1'b0, 0, 1'b0};
        vecs[3] = '{18'd262143, 18'd262143, 18'd1,      18'd0,    1'b0, 0, 1'b0};
        vecs[4] = '{18'd1234,   18'd0,      18'h3FFFF,  18'd1234, 1'b1, 0, 1'b0};
        vecs[5] = '{18'd1000,   18'd3,      18'd333,    18'd1,    1'b0, 6, 1'b1};
        vecs[6] = '{18'd0,      18'd5,      18'd0,      18'd0,    1'b0, 0, 1'b0};

        #1;
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset q", 64'(q), 64'd0);
        check("reset r", 64'(r), 64'd0);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        #21 rst = 1'b0;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                  vecs[i].dbz, vecs[i].stall, vecs[i].pulse);

        // Asynchronous reset in the middle of a running operation.
        @(negedge clk);
        a = 18'd100; b = 18'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst q", 64'(q), 64'd0);
        check("midrst r", 64'(r), 64'd0);
        check("midrst dbz", 64'(div_by_zero), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("post rst in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no result after rst", 64'(seen), 64'd0);
        out_ready = 1'b0;
        do_op("post rst op", 18'd50, 18'd6, 18'd8, 18'd2, 1'b0, 0, 1'b0);

        // Random pairs with a share of zero divisors and random backpressure.
        void'($urandom(23));
        for (int n = 0; n < 1500; n++) begin
            ra = W'($urandom());
            lat = int'($urandom_range(0, 9));
            if (lat == 0)      rb = '0;
            else if (lat < 4)  rb = W'($urandom_range(1, 15));
            else               rb = W'($urandom());
            if (rb == '0) begin
                rq = MAXV; rr = ra; rd = 1'b1;
            end else begin
                rq = ra / rb; rr = ra % rb; rd = 1'b0;
            end
            do_op($sformatf("rnd%0d a=%0d b=%0d", n, ra, rb), ra, rb, rq, rr, rd,
                  int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
